gpio_ctrl: RTL
==============

// Module: gpio_ctrl
// PURPOSE
//   Register-mapped GPIO controller sitting directly upstream of the tri-state pad cells.
//   Per bit it drives drive_enable/drive_value into one pad cell and samples port_value back.
//   The sampled input passes a 2-flop synchronizer, then edge detection latches interrupt pending bits.
//   The CPU reaches it through a simple single-cycle register bus.
// PARAMETERS
//   WIDTH     8   number of GPIO bits (1..32)
// PORTS
//   clk           in   1      system clock, all logic on rising edge
//   rst           in   1      synchronous reset, active high
//   sel           in   1      bus access strobe, one cycle per access
//   we            in   1      1=write, 0=read (qualified by sel)
//   addr          in   3      register index
//   wdata         in   WIDTH  write data
//   rdata         out  WIDTH  read data, registered
//   rvalid        out  1      one-cycle pulse, rdata valid
//   irq           out  1      level interrupt, registered
//   drive_enable  out  WIDTH  per-bit pad output enable (1=drive)
//   drive_value   out  WIDTH  per-bit pad output value
//   port_value    in   WIDTH  per-bit pad sampled value (asynchronous)
// BEHAVIOUR
// - Register map:
//   - 0 DIR (rw): 1 = output.
//   - 1 OUT (rw).
//   - 2 IN (ro): synchronized pad value.
//   - 3 IE (rw): interrupt enable.
//   - 4 EDGE (rw): 1 = rising, 0 = falling.
//   - 5 PEND (r/W1C).
//   - 6, 7: read 0, writes ignored. Writes to IN ignored.
// - Reset: DIR, OUT, IE, EDGE, PEND, sync1, sync2, prev, rdata, rvalid, irq all 0.
//   - All pads therefore come up hi-z.
//   - Warm-up counter wu = 0.
// - Pad outputs:
//   - drive_enable = DIR, drive_value = OUT, straight from the registers.
//   - A write at edge k is visible on the pads after edge k.
// - Write: sel&we at edge k updates the register at k.
// - Read:
//   - sel&~we at edge k loads rdata and asserts rvalid for the cycle after k.
//   - rvalid = 0 otherwise; rdata holds its last value.
// - Synchronizer: sync1 <= port_value; sync2 <= sync1; prev <= sync2. IN = sync2.
//   - A pad change before edge k appears in IN after edge k+1.
// - Edge detect: rise = sync2 & ~prev; fall = ~sync2 & prev; hit = EDGE ? rise : fall.
//   - PEND[i] sets at the edge following the cycle where hit[i] = 1, i.e. after edge k+2.
// - Warm-up:
//   - 2-bit wu counts 0..3 after reset and saturates.
//   - While wu != 3, PEND does not set. This masks spurious edges from sync flops clearing to 0.
// - PEND update: PEND <= (PEND & ~w1c) | (hit & {WIDTH{wu==3}}).
//   - w1c = wdata when writing addr 5.
//   - Simultaneous clear and new hit on the same bit: set wins, bit stays 1.
// - irq <= |(PEND & IE), one cycle after PEND/IE change.
//   - Clearing IE drops irq without touching PEND.
// - Edge detection runs on every bit regardless of DIR, so output bits loop back and can interrupt.
// - rst asserted mid-operation: at the next edge all state returns to reset values.
//   - Pads go hi-z, pending interrupts are lost, warm-up restarts.
// TESTING
// - Reset, then read all 8 addrs -> DIR/OUT/IE/EDGE/PEND = 0, addr 6/7 = 0; drive_enable = 0; rvalid 1 cycle per read.
// - Write DIR=0xF0, OUT=0xA5 -> drive_enable=0xF0, drive_value=0xA5 the cycle after the write; write addr 2 has no effect.
// - EDGE=0x01, IE=0x01; port_value[0] 0->1 before edge k:
//   - IN[0]=1 after k+1, PEND[0]=1 after k+2, irq=1 after k+3.
//   - port_value[1] rising with EDGE[1]=0 -> PEND[1] stays 0.
// - Drive port_value=0xFF through reset release -> PEND stays 0x00 (warm-up mask); a later falling edge on bit 3 with EDGE=0 sets PEND=0x08.
// - W1C 0x01 on PEND in the same cycle that hit[0]=1 -> PEND[0] stays 1.
//   - A W1C 0x01 with no new hit clears it; irq falls one cycle later.
// - Set PEND=0x01, DIR=0xFF, assert rst for 1 cycle mid-run -> all registers 0, pads hi-z, irq=0 after the reset edge.

Source files
------------

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO block feeding tri-state pad cells.
// Pads are driven straight from DIR/OUT. Inputs pass a 2-flop synchronizer,
// then per-bit edge detection latches pending bits that raise a level irq.
module gpio_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             irq,
    output logic [WIDTH-1:0] drive_enable,
    output logic [WIDTH-1:0] drive_value,
    input  logic [WIDTH-1:0] port_value
);

    localparam logic [2:0] ADDR_DIR  = 3'd0;
    localparam logic [2:0] ADDR_OUT  = 3'd1;
    localparam logic [2:0] ADDR_IN   = 3'd2;
    localparam logic [2:0] ADDR_IE   = 3'd3;
    localparam logic [2:0] ADDR_EDGE = 3'd4;
    localparam logic [2:0] ADDR_PEND = 3'd5;

    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] ie;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [1:0]       wu;

    logic             wr_en;
    logic             rd_en;
    logic             armed;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rd_mux;

    assign wr_en        = sel & we;
    assign rd_en        = sel & ~we;
    assign armed        = (wu == 2'd3);
    assign drive_enable = dir;
    assign drive_value  = out_reg;

    // Per-bit edge hit, polarity chosen by EDGE (1 = rising, 0 = falling)
    always_comb begin
        hit = (edge_sel & sync2 & ~prev) | (~edge_sel & ~sync2 & prev);
    end

    // Write-one-to-clear mask, only active on a write to PEND
    always_comb begin
        w1c = '0;
        if (wr_en && addr == ADDR_PEND) begin
            w1c = wdata;
        end
    end

    // Read data selection; unmapped addresses read as zero
    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_DIR:  rd_mux = dir;
            ADDR_OUT:  rd_mux = out_reg;
            ADDR_IN:   rd_mux = sync2;
            ADDR_IE:   rd_mux = ie;
            ADDR_EDGE: rd_mux = edge_sel;
            ADDR_PEND: rd_mux = pend;
            default:   rd_mux = '0;
        endcase
    end

    // Writable configuration registers; IN and addresses 6/7 ignore writes
    always_ff @(posedge clk) begin
        if (rst) begin
            dir      <= '0;
            out_reg  <= '0;
            ie       <= '0;
            edge_sel <= '0;
        end else if (wr_en) begin
            case (addr)
                ADDR_DIR:  dir      <= wdata;
                ADDR_OUT:  out_reg  <= wdata;
                ADDR_IE:   ie       <= wdata;
                ADDR_EDGE: edge_sel <= wdata;
                default:   ;
            endcase
        end
    end

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= port_value;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Warm-up counter: hides the fake edges the synchronizer sees as it fills after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wu <= 2'd0;
        end else if (!armed) begin
            wu <= wu + 2'd1;
        end
    end

    // Pending bits: new hits win over a simultaneous W1C on the same bit
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~w1c) | (hit & {WIDTH{armed}});
        end
    end

    // Registered read port: rvalid pulses one cycle, rdata holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= rd_mux;
            end
        end
    end

    // Level interrupt from enabled pending bits
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(pend & ie);
        end
    end

endmodule
